piso_serializer: RTL

- Parallel-in serial-out transmitter. It is the serial-side counterpart to the team's PIPO register bank.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per bit_en strobe.
- Drives frame markers so a downstream SIPO receiver can re-align words.
- Sits between a parallel data source and a serial link, sharing the same clock domain.

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_bit_counter.sv | 39 +++
 rtl/piso_serializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared constants for the PISO transmitter and its matching SIPO receiver.
// State encodings are a 2-bit localparam set so legacy code can reuse them.
package piso_pkg;

  localparam int PISO_WIDTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: clear on load, count on each
// strobe, and flag the last data bit position (WIDTH-1).
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first shift
// on bit_en, with frame markers. Define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  input  logic             bit_en,
  output logic             sdata,
  output logic             sframe,
  output logic             sfirst,
  output logic             slast
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             cnt_inc;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The source may hand over the next word on the same strobe that retires
  // the final bit of the current frame, giving gap-free back-to-back frames.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    pready = 1'b0;
    case (state_q)
      ST_IDLE:   pready = 1'b1;
`ifdef PISO_PARITY_EN
      ST_PARITY: pready = bit_en;
`else
      ST_SHIFT:  pready = cnt_last & bit_en;
`endif
      default:   pready = 1'b0;
    endcase
  end

  assign accept  = pvalid & pready;
  assign cnt_inc = bit_en & (state_q == ST_SHIFT);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d  = ST_SHIFT;
      shift_d  = pdata;
`ifdef PISO_PARITY_EN
      parity_d = ^pdata;
`endif
    end else if (bit_en) begin
      case (state_q)
        ST_SHIFT: begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_last) begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: state_d = ST_IDLE;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (accept),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // Serial outputs decode only registered state, never pdata directly.
  always_comb begin
    sdata  = 1'b0;
    sframe = 1'b0;
    sfirst = 1'b0;
    slast  = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        sdata  = shift_q[WIDTH-1];
        sframe = 1'b1;
        sfirst = (cnt == '0);
`ifndef PISO_PARITY_EN
        slast  = cnt_last;
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        sdata  = parity_q;
        sframe = 1'b1;
        slast  = 1'b1;
      end
`endif
      default: begin
        sdata  = 1'b0;
        sframe = 1'b0;
      end
    endcase
  end

endmodule
